// File: rtl/ap_com_lut_bank.sv
// Bank of NUM_CH independent K-input LUT compressors with double-buffered truth tables.
// Tables are staged into shadow copies and swapped into active in one cycle on commit.

module ap_com_lut_lane #(
   parameter int                    LUT_K       = 4,
   parameter logic [2**LUT_K-1:0]   RESET_TABLE = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic                     swap,
   input  logic [2**LUT_K-1:0]      cfg_table,
   input  logic                     in_valid,
   input  logic [LUT_K-1:0]         in_idx,
   output logic                     pending,
   output logic                     y
);
   logic [2**LUT_K-1:0] active, shadow;

   // Evaluation reads the pre-edge active table, so a sample taken during the
   // swap cycle still sees the old table in full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= RESET_TABLE;
         shadow  <= RESET_TABLE;
         pending <= 1'b0;
         y       <= 1'b0;
      end else begin
         if (wr_en) begin
            shadow  <= cfg_table;
            pending <= 1'b1;
         end
         if (swap) begin
            if (pending) active <= shadow;
            pending <= 1'b0;
         end
         if (in_valid) y <= active[in_idx];
      end
   end
endmodule

module ap_com_lut_bank #(
   parameter int                    NUM_CH      = 14,
   parameter int                    LUT_K       = 4,
   parameter logic [2**LUT_K-1:0]   RESET_TABLE = '0,
   localparam int                   TW          = 2**LUT_K,
   localparam int                   CW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [CW-1:0]            cfg_ch,
   input  logic [TW-1:0]            cfg_table,
   input  logic                     cfg_commit,
   output logic                     cfg_err,
   input  logic                     in_valid,
   input  logic [NUM_CH*LUT_K-1:0]  in_data,
   output logic                     out_valid,
   output logic [NUM_CH-1:0]        out_y,
   output logic                     commit_pending
);
   typedef enum logic {IDLE, SWAP} state_t;

   // One extra bit so NUM_CH == 2**CW is representable in the range check.
   localparam logic [CW:0] NUM_CH_W = (CW+1)'(NUM_CH);

   state_t              state;
   logic                hs, addr_ok, wr_ok, swap;
   logic [NUM_CH-1:0]   pend_vec;

   assign hs             = cfg_valid & cfg_ready;
   assign addr_ok        = {1'b0, cfg_ch} < NUM_CH_W;
   assign wr_ok          = hs & addr_ok;
   assign swap           = (state == SWAP);
   assign commit_pending = |pend_vec;

   // A write accepted alongside the commit counts as pending for the swap decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cfg_ready <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         if (hs && !addr_ok) cfg_err <= 1'b1;
         case (state)
            IDLE: begin
               cfg_ready <= 1'b1;
               if (cfg_commit && (commit_pending || wr_ok)) begin
                  state     <= SWAP;
                  cfg_ready <= 1'b0;
               end
            end
            SWAP: begin
               state     <= IDLE;
               cfg_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_valid <= 1'b0;
      else        out_valid <= in_valid;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      localparam logic [CW-1:0] CH_ID = CW'(c);
      ap_com_lut_lane #(
         .LUT_K       (LUT_K),
         .RESET_TABLE (RESET_TABLE)
      ) u_lane (
         .clk         (clk),
         .rst_n       (rst_n),
         .wr_en       (wr_ok && (cfg_ch == CH_ID)),
         .swap        (swap),
         .cfg_table   (cfg_table),
         .in_valid    (in_valid),
         .in_idx      (in_data[c*LUT_K +: LUT_K]),
         .pending     (pend_vec[c]),
         .y           (out_y[c])
      );
   end
endmodule

// File: tb/tb_ap_com_lut_bank.sv
// Directed bench for ap_com_lut_bank: main instance NUM_CH=4, plus a NUM_CH=5
// instance whose 3-bit cfg_ch can carry the out-of-range address 5.

module tb_ap_com_lut_bank;
   logic clk = 1'b0;
   logic rst_n;

   logic        cfg_valid, cfg_ready, cfg_commit, cfg_err;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_table;
   logic        in_valid, out_valid, commit_pending;
   logic [15:0] in_data;
   logic [3:0]  out_y;

   logic        b_cfg_valid, b_cfg_ready, b_cfg_commit, b_cfg_err;
   logic [2:0]  b_cfg_ch;
   logic [15:0] b_cfg_table;
   logic        b_in_valid, b_out_valid, b_commit_pending;
   logic [19:0] b_in_data;
   logic [4:0]  b_out_y;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ap_com_lut_bank #(.NUM_CH(4), .LUT_K(4), .RESET_TABLE(16'h0000)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_table(cfg_table), .cfg_commit(cfg_commit), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_y(out_y),
      .commit_pending(commit_pending)
   );

   ap_com_lut_bank #(.NUM_CH(5), .LUT_K(4), .RESET_TABLE(16'h0000)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
      .cfg_ch(b_cfg_ch), .cfg_table(b_cfg_table), .cfg_commit(b_cfg_commit), .cfg_err(b_cfg_err),
      .in_valid(b_in_valid), .in_data(b_in_data), .out_valid(b_out_valid), .out_y(b_out_y),
      .commit_pending(b_commit_pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_valid = 0; cfg_ch = '0; cfg_table = '0; cfg_commit = 0; in_valid = 0; in_data = '0;
      b_cfg_valid = 0; b_cfg_ch = '0; b_cfg_table = '0; b_cfg_commit = 0; b_in_valid = 0; b_in_data = '0;
      tick(); tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_y", 32'(out_y), 0);
      chk("rst_pending", 32'(commit_pending), 0);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(cfg_ready), 1);

      // post-reset evaluation with all-zero tables
      in_valid = 1; in_data = 16'hBEEF;
      tick();
      chk("post_rst_out_valid", 32'(out_valid), 1);
      chk("post_rst_out_y", 32'(out_y), 0);
      in_valid = 0;
      tick();
      chk("out_valid_drop", 32'(out_valid), 0);

      // load ch0 = FFF0 and commit
      cfg_valid = 1; cfg_ch = 2'd0; cfg_table = 16'hFFF0;
      tick();
      cfg_valid = 0;
      chk("ch0_pending", 32'(commit_pending), 1);
      cfg_commit = 1;
      tick();
      cfg_commit = 0;
      chk("commit_ready_low", 32'(cfg_ready), 0);
      tick();
      chk("commit_ready_back", 32'(cfg_ready), 1);
      chk("commit_pending_clr", 32'(commit_pending), 0);
      in_valid = 1; in_data = 16'h0004;
      tick();
      chk("ch0_idx4", 32'(out_y[0]), 1);
      in_data = 16'h0003;
      tick();
      chk("ch0_idx3", 32'(out_y[0]), 0);
      in_valid = 0;

      // shadow isolation on ch1 = AAAA
      cfg_valid = 1; cfg_ch = 2'd1; cfg_table = 16'hAAAA;
      tick();
      cfg_valid = 0;
      in_valid = 1; in_data = 16'h0010;
      tick();
      chk("ch1_shadow_old", 32'(out_y[1]), 0);
      chk("ch1_shadow_pend", 32'(commit_pending), 1);
      cfg_commit = 1;
      tick();
      cfg_commit = 0;
      tick();
      chk("ch1_swap_cycle_old", 32'(out_y[1]), 0);
      tick();
      chk("ch1_after_commit", 32'(out_y[1]), 1);
      chk("ch1_pend_clr", 32'(commit_pending), 0);
      in_valid = 0;

      // write + commit + sample in the same cycle on ch2
      cfg_valid = 1; cfg_ch = 2'd2; cfg_table = 16'hFFFF; cfg_commit = 1;
      in_valid = 1; in_data = 16'h0000;
      tick();
      cfg_valid = 0; cfg_commit = 0; in_valid = 0;
      chk("same_cyc_old", 32'(out_y), 32'h0);
      chk("same_cyc_ready", 32'(cfg_ready), 0);
      tick();
      chk("same_cyc_hold", 32'(out_y), 32'h0);
      in_valid = 1;
      tick();
      chk("same_cyc_new", 32'(out_y), 32'h4);
      in_valid = 0;

      // commit with nothing pending is a no-op
      cfg_commit = 1;
      tick();
      cfg_commit = 0;
      chk("empty_commit_ready", 32'(cfg_ready), 1);
      chk("empty_commit_err", 32'(cfg_err), 0);

      // out-of-range channel on the 5-channel instance
      b_cfg_valid = 1; b_cfg_ch = 3'd5; b_cfg_table = 16'hFFFF;
      tick();
      b_cfg_valid = 0;
      chk("bad_ch_err", 32'(b_cfg_err), 1);
      chk("bad_ch_pend", 32'(b_commit_pending), 0);
      b_cfg_commit = 1;
      tick();
      b_cfg_commit = 0;
      chk("bad_ch_commit_ready", 32'(b_cfg_ready), 1);
      b_in_valid = 1; b_in_data = 20'hFFFFF;
      tick();
      tick();
      b_in_valid = 0;
      chk("bad_ch_out_y", 32'(b_out_y), 0);
      chk("bad_ch_err_sticky", 32'(b_cfg_err), 1);

      // reset asserted during SWAP for ch3
      cfg_valid = 1; cfg_ch = 2'd3; cfg_table = 16'hFFFF;
      tick();
      cfg_valid = 0; cfg_commit = 1;
      tick();
      cfg_commit = 0;
      chk("mid_swap_ready", 32'(cfg_ready), 0);
      rst_n = 0;
      #1;
      chk("mid_swap_async_pend", 32'(commit_pending), 0);
      chk("mid_swap_async_ready", 32'(cfg_ready), 0);
      tick();
      rst_n = 1;
      tick();
      chk("mid_swap_ready_back", 32'(cfg_ready), 1);
      chk("rst_clears_err", 32'(b_cfg_err), 0);
      in_valid = 1; in_data = 16'hF000;
      tick();
      in_valid = 0;
      chk("mid_swap_ch3", 32'(out_y[3]), 0);
      in_data = 16'h0004;
      in_valid = 1;
      tick();
      in_valid = 0;
      chk("mid_swap_ch0_reset", 32'(out_y), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ap_com_lut_bank.md
AP_COM_LUT_BANK -- requirements
Module: ap_com_lut_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 14, giving the number of independent compressor channels.
REQ-002 SHALL have parameter LUT_K, default 4, giving inputs per channel; the truth table width is TW = 2^LUT_K.
REQ-003 SHALL have parameter RESET_TABLE, TW bits, default all-zero, giving the truth table every channel loads at reset.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port cfg_valid, input, 1 bit: table-write request.
REQ-008 SHALL have port cfg_ready, output, 1 bit: table write accepted when cfg_valid and cfg_ready are high at an edge.
REQ-009 SHALL have port cfg_ch, input, CW = max(1, clog2(NUM_CH)) bits: target channel.
REQ-010 SHALL have port cfg_table, input, TW bits: truth table; bit i is the output for input index i.
REQ-011 SHALL have port cfg_commit, input, 1 bit: single-cycle pulse that swaps shadow tables into active.
REQ-012 SHALL have port cfg_err, output, 1 bit: sticky error flag.
REQ-013 SHALL have port in_valid, input, 1 bit: qualifies in_data.
REQ-014 SHALL have port in_data, input, NUM_CH*LUT_K bits: channel c occupies bits [c*LUT_K +: LUT_K], MSB-first as {a,b,c,d}.
REQ-015 SHALL have port out_valid, output, 1 bit: qualifies out_y.
REQ-016 SHALL have port out_y, output, NUM_CH bits: bit c is the compressor output of channel c.
REQ-017 SHALL have port commit_pending, output, 1 bit: at least one shadow write is not yet committed.

Function
REQ-018 SHALL hold per channel an active table and a shadow table, each TW bits.
REQ-019 SHALL write cfg_table into the shadow table of cfg_ch on a cfg handshake, and set that channel's pending bit.
REQ-020 SHALL, when a handshake arrives with cfg_ch >= NUM_CH, write nothing, set cfg_err, and keep cfg_err set until reset.
REQ-021 SHALL use a two-state FSM: SHALL go from IDLE to SWAP when cfg_commit is sampled high and any pending bit is set; SHALL return from SWAP to IDLE unconditionally after one cycle.
REQ-022 SHALL, in SWAP, copy the shadow table into the active table for pending channels only, then clear all pending bits.
REQ-023 SHALL treat a cfg_commit sampled with no pending bits as a no-op, with no state change and no error.
REQ-024 SHALL drive cfg_ready high in IDLE and low in SWAP.
REQ-025 SHALL, when cfg_valid and cfg_commit arrive in the same cycle, accept the write first; that write is included in the commit.
REQ-026 SHALL drive commit_pending as the OR of the pending bits.
REQ-027 SHALL have a latency of exactly 1 cycle: out_valid(t+1) = in_valid(t), and out_y[c](t+1) = active_c(t)[in_data channel c value at t].
REQ-028 SHALL evaluate inputs sampled in the same cycle the active table is being updated using the old active table, so no sample sees a mixed table.
REQ-029 SHALL hold out_y at its last value when in_valid is low; the datapath has no backpressure and accepts input every cycle.
REQ-030 SHALL keep the datapath independent of the FSM: evaluation never stalls during SWAP.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously load RESET_TABLE into all active and shadow tables, and clear all pending bits, cfg_err, out_valid and out_y; the FSM goes to IDLE.
REQ-032 SHALL drive cfg_ready high from the first edge after rst_n deasserts.
REQ-033 SHALL, when reset is asserted during SWAP, abandon the swap; afterwards every active table equals RESET_TABLE.

Verification (NUM_CH=4, LUT_K=4, RESET_TABLE=0)
REQ-034 SHALL cover post-reset: in_valid=1 with any in_data -> out_valid=1 and out_y=4'b0000 one cycle later; cfg_ready=1, cfg_err=0.
REQ-035 SHALL cover load and commit: write ch0 table 16'hFFF0, then pulse commit; in_data ch0=4'b0100 -> out_y[0]=1; ch0=4'b0011 -> out_y[0]=0; cfg_ready is low for exactly 1 cycle after the commit.
REQ-036 SHALL cover shadow isolation: write ch1 table 16'hAAAA with no commit, drive ch1=4'b0001 -> out_y[1]=0 and commit_pending=1; after commit -> out_y[1]=1 and commit_pending=0.
REQ-037 SHALL cover the same-cycle case: cfg write of ch2 table 16'hFFFF together with cfg_commit and in_valid (ch2=4'b0000) -> that sample gives out_y[2]=0; the next sample gives out_y[2]=1.
REQ-038 SHALL cover a bad address: write with cfg_ch=5 -> cfg_err=1 and stays 1, and no out_y change after commit; commit with nothing pending -> cfg_ready stays 1.
REQ-039 SHALL cover reset mid-SWAP: commit ch3 table 16'hFFFF and assert rst_n=0 in the SWAP cycle -> after release, ch3=4'b1111 gives out_y[3]=0.
